// File: rtl/xy2_pkg.sv
// Shared XY2-100 link constants and receiver state encoding.
// The on-chip transmitter uses the same frame geometry.
package xy2_pkg;

   localparam int FRAME_BITS = 20;
   localparam int DATA_BITS  = 16;
   localparam int CTRL_BITS  = 3;
   localparam int CNT_W      = 5;

   localparam logic [CTRL_BITS-1:0] CTRL_WD = 3'b001;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_RECV,
      RX_DONE,
      RX_RESYNC
   } rx_state_t;

   // Even parity over the whole frame: an even number of ones is good.
   function automatic logic par_even_ok(input logic [FRAME_BITS-1:0] word);
      return ~^word;
   endfunction

endpackage

// File: rtl/xy2_sync_edge.sv
// Two-flop synchronizer for the four link lines plus a sendck falling-edge strobe.
// The sync/data outputs are valid in the same cycle as smp_stb.
module xy2_sync_edge
   import xy2_pkg::*;
(
   input  logic clk50m,
   input  logic rst_n,
   input  logic sendck,
   input  logic sync,
   input  logic chl_x,
   input  logic chl_y,
   output logic sync_s,
   output logic x_s,
   output logic y_s,
   output logic smp_stb
);

   logic [3:0] meta_q;
   logic [3:0] stab_q;
   logic       sck_d_q;

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         meta_q  <= '0;
         stab_q  <= '0;
         sck_d_q <= 1'b0;
      end else begin
         meta_q  <= {sendck, sync, chl_x, chl_y};
         stab_q  <= meta_q;
         sck_d_q <= stab_q[3];
      end
   end

   // Data lines share the clock line's latency, so they are sampled mid-bit.
   assign smp_stb = sck_d_q & ~stab_q[3];
   assign sync_s  = stab_q[2];
   assign x_s     = stab_q[1];
   assign y_s     = stab_q[0];

endmodule

// File: rtl/xy2_100_rx.sv
// XY2-100 galvo link receiver: deframes 20-bit X/Y words (ctrl, data, parity)
// and reports checked positions together with per-frame error status.
module xy2_100_rx
   import xy2_pkg::*;
#(
   parameter int                   TIMEOUT_CYC = 64,
   parameter logic [CTRL_BITS-1:0] CTRL_EXP    = CTRL_WD
)
(
   input  logic                 clk50m,
   input  logic                 rst_n,
   input  logic                 sendck,
   input  logic                 sync,
   input  logic                 chl_x,
   input  logic                 chl_y,
   output logic [DATA_BITS-1:0] x_data,
   output logic [DATA_BITS-1:0] y_data,
   output logic                 rx_valid,
   output logic                 rx_err,
   output logic                 par_err_x,
   output logic                 par_err_y,
   output logic                 ctrl_err,
   output logic                 frame_err,
   output logic                 rx_busy
);

   localparam int TW = $clog2(TIMEOUT_CYC);

   logic sync_s;
   logic x_s;
   logic y_s;
   logic smp_stb;

   rx_state_t state;
   rx_state_t state_n;

   logic [CNT_W-1:0]      bit_cnt;
   logic [FRAME_BITS-2:0] sr_x;
   logic [FRAME_BITS-2:0] sr_y;
   logic [FRAME_BITS-1:0] sx_n;
   logic [FRAME_BITS-1:0] sy_n;
   logic [TW-1:0]         timer;

   logic last_bit;
   logic tmo;
   logic start;
   logic shift_more;
   logic frame_end;
   logic abort;
   logic shift_en;

   logic x_par_bad;
   logic y_par_bad;
   logic ctrl_bad;
   logic any_bad;

   xy2_sync_edge u_sync_edge (
      .clk50m  (clk50m),
      .rst_n   (rst_n),
      .sendck  (sendck),
      .sync    (sync),
      .chl_x   (chl_x),
      .chl_y   (chl_y),
      .sync_s  (sync_s),
      .x_s     (x_s),
      .y_s     (y_s),
      .smp_stb (smp_stb)
   );

   // Only 19 bits of history are stored; the parity bit is the live sample.
   assign sx_n = {sr_x, x_s};
   assign sy_n = {sr_y, y_s};

   assign last_bit = (bit_cnt == CNT_W'(FRAME_BITS - 1));
   assign tmo      = (state == RX_RECV) && (timer == TW'(TIMEOUT_CYC - 1));

   assign x_par_bad = ~par_even_ok(sx_n);
   assign y_par_bad = ~par_even_ok(sy_n);
   assign ctrl_bad  = (sx_n[FRAME_BITS-1 -: CTRL_BITS] != CTRL_EXP) ||
                      (sy_n[FRAME_BITS-1 -: CTRL_BITS] != CTRL_EXP);
   assign any_bad   = x_par_bad | y_par_bad | ctrl_bad;

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         state <= RX_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         RX_IDLE: begin
            if (smp_stb && sync_s) begin
               state_n = RX_RECV;
            end
         end
         RX_RECV: begin
            if (smp_stb) begin
               if (sync_s) begin
                  if (last_bit) begin
                     state_n = RX_RESYNC;
                  end
               end else if (last_bit) begin
                  state_n = RX_DONE;
               end else begin
                  state_n = RX_IDLE;
               end
            end else if (tmo) begin
               state_n = RX_IDLE;
            end
         end
         RX_DONE: begin
            if (smp_stb && sync_s) begin
               state_n = RX_RECV;
            end else begin
               state_n = RX_IDLE;
            end
         end
         RX_RESYNC: begin
            if (smp_stb && !sync_s) begin
               state_n = RX_IDLE;
            end
         end
         default: begin
            state_n = RX_IDLE;
         end
      endcase
   end

   always_comb begin
      start      = 1'b0;
      shift_more = 1'b0;
      frame_end  = 1'b0;
      abort      = 1'b0;
      rx_busy    = (state != RX_IDLE);
      case (state)
         RX_IDLE, RX_DONE: begin
            start = smp_stb & sync_s;
         end
         RX_RECV: begin
            if (smp_stb) begin
               if (sync_s) begin
                  abort      = last_bit;
                  shift_more = ~last_bit;
               end else begin
                  frame_end = last_bit;
                  abort     = ~last_bit;
               end
            end else begin
               abort = tmo;
            end
         end
         default: begin
            start = 1'b0;
         end
      endcase
      shift_en = start | shift_more | frame_end;
   end

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         sr_x    <= '0;
         sr_y    <= '0;
         bit_cnt <= '0;
      end else begin
         if (shift_en) begin
            sr_x <= sx_n[FRAME_BITS-2:0];
            sr_y <= sy_n[FRAME_BITS-2:0];
         end
         if (start) begin
            bit_cnt <= CNT_W'(1);
         end else if (shift_more) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
         end else if (frame_end || abort) begin
            bit_cnt <= '0;
         end
      end
   end

   // Timer reads 1 in the cycle after a sample event, so an abort lands
   // TIMEOUT_CYC cycles after the last one.
   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         timer <= '0;
      end else if (smp_stb) begin
         timer <= TW'(1);
      end else if (state == RX_RECV) begin
         timer <= timer + TW'(1);
      end else begin
         timer <= '0;
      end
   end

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         x_data    <= '0;
         y_data    <= '0;
         rx_valid  <= 1'b0;
         rx_err    <= 1'b0;
         par_err_x <= 1'b0;
         par_err_y <= 1'b0;
         ctrl_err  <= 1'b0;
         frame_err <= 1'b0;
      end else if (frame_end) begin
         x_data    <= sx_n[DATA_BITS:1];
         y_data    <= sy_n[DATA_BITS:1];
         par_err_x <= x_par_bad;
         par_err_y <= y_par_bad;
         ctrl_err  <= ctrl_bad;
         frame_err <= 1'b0;
         rx_valid  <= ~any_bad;
         rx_err    <= any_bad;
      end else if (abort) begin
         par_err_x <= 1'b0;
         par_err_y <= 1'b0;
         ctrl_err  <= 1'b0;
         frame_err <= 1'b1;
         rx_valid  <= 1'b0;
         rx_err    <= 1'b1;
      end else begin
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
      end
   end

endmodule
